// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants.
// Used by the fetch stage and its IF/ID register.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, stall-hold, flush-clear.
// An empty slot always presents NOP with fault cleared.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            id_ready,
  input  fetch_entry_t    entry,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_fault
);

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_instr <= NOP;
      if_id_fault <= 1'b0;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_fault <= 1'b0;
    end else if (load) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= entry.pc;
      if_id_pc4   <= entry.pc + 32'd4;
      if_id_instr <= entry.instr;
      if_id_fault <= entry.fault;
    end else if (id_ready) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_fault <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: one outstanding imem request,
// one-entry hold buffer for decode stalls, flush discard.
module fetch_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_en,
  fetch_unit_if.master    imem,
  input  logic            id_ready,
  input  logic            flush,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_fault
);

  fetch_state_t    state;
  fetch_state_t    state_nx;
  logic [XLEN-1:0] req_pc;
  logic            discard;
  fetch_entry_t    hold_q;
  fetch_entry_t    rsp_entry;
  fetch_entry_t    load_entry;

  logic misal;
  logic slot_free;
  logic rsp_evt;
  logic drop;
  logic accept;
  logic park;
  logic unload;
  logic load;

  // A misaligned PC in FETCH acts as an immediate faulted response.
  always_comb begin
    misal     = pc_in[1:0] != 2'b00;
    slot_free = !if_id_valid || id_ready;
    rsp_evt   = (state == FETCH && misal)
             || (state == WAIT && imem.imem_rvalid);
    drop      = flush || (state == WAIT && discard);
    accept    = rsp_evt && !drop && slot_free;
    park      = rsp_evt && !drop && !slot_free;
    unload    = state == HOLD && !flush && id_ready;
    rsp_entry.pc    = (state == FETCH) ? pc_in : req_pc;
    rsp_entry.instr = (state == FETCH) ? NOP : imem.imem_rdata;
    rsp_entry.fault = state == FETCH;
    load_entry = unload ? hold_q : rsp_entry;
  end

  assign load  = !rst && (accept || unload);
  assign pc_en = load;

  assign imem.imem_req  = !rst && state == FETCH && !misal;
  assign imem.imem_addr = imem.imem_req ? pc_in : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (!misal)    state_nx = WAIT;
        else if (park) state_nx = HOLD;
        else           state_nx = FETCH;
      end
      WAIT: begin
        if (imem.imem_rvalid)
          state_nx = park ? HOLD : FETCH;
      end
      HOLD: begin
        if (flush || id_ready) state_nx = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_pc  <= '0;
      discard <= 1'b0;
      hold_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH) begin
        req_pc  <= pc_in;
        discard <= 1'b0;
      end else if (state == WAIT && flush
                   && !imem.imem_rvalid) begin
        discard <= 1'b1;
      end
      if (park) hold_q <= rsp_entry;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .flush       (flush),
    .id_ready    (id_ready),
    .entry       (load_entry),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_fault (if_id_fault)
  );

endmodule
